// File: rtl/alu_pkg.sv
// Shared op codes, op classification and FSM states for the ALU/MDU.
package alu_pkg;

   localparam logic [3:0] OP_AND   = 4'b0000;
   localparam logic [3:0] OP_OR    = 4'b0001;
   localparam logic [3:0] OP_ADD   = 4'b0010;
   localparam logic [3:0] OP_SLL   = 4'b0011;
   localparam logic [3:0] OP_SLTU  = 4'b0100;
   localparam logic [3:0] OP_SUB   = 4'b0110;
   localparam logic [3:0] OP_SLT   = 4'b0111;
   localparam logic [3:0] OP_MULT  = 4'b1000;
   localparam logic [3:0] OP_MULTU = 4'b1001;
   localparam logic [3:0] OP_DIV   = 4'b1010;
   localparam logic [3:0] OP_DIVU  = 4'b1011;
   localparam logic [3:0] OP_NOR   = 4'b1100;
   localparam logic [3:0] OP_MFHI  = 4'b1110;
   localparam logic [3:0] OP_MFLO  = 4'b1111;

   typedef enum logic [1:0] {
      CLS_SINGLE,
      CLS_MUL,
      CLS_DIV,
      CLS_MOVE
   } op_class_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_FIX
   } state_e;

   function automatic op_class_e op_class(input logic [3:0] op);
      case (op)
         OP_MULT, OP_MULTU: op_class = CLS_MUL;
         OP_DIV, OP_DIVU:   op_class = CLS_DIV;
         OP_MFHI, OP_MFLO:  op_class = CLS_MOVE;
         default:           op_class = CLS_SINGLE;
      endcase
   endfunction

endpackage

// File: rtl/mdu_core.sv
// Iterative multiply/divide datapath: shift-add multiply and restoring divide on
// operand magnitudes, with signs and divide-by-zero applied on the way out.
module mdu_core
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic             step,
   input  logic             finish,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             last,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             div_zero
);

   localparam int CW = $clog2(WIDTH);

   logic [CW-1:0]      count;
   logic [WIDTH-1:0]   acc;
   logic [WIDTH-1:0]   low;
   logic [WIDTH-1:0]   divisor;
   logic [WIDTH-1:0]   a_keep;
   logic               is_div;
   logic               neg_lo;
   logic               neg_hi;
   logic               b_zero;

   logic               op_signed;
   logic               op_div;
   logic [WIDTH:0]     add_sum;
   logic [WIDTH:0]     shifted;
   logic               fits;
   logic [WIDTH-1:0]   diff;
   logic [WIDTH-1:0]   acc_nxt;
   logic [WIDTH-1:0]   low_nxt;
   logic [2*WIDTH-1:0] prod;

   // Magnitude of the most negative value wraps to itself, which is the
   // correct unsigned magnitude.
   function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                  input logic             sgn);
      return (sgn && v[WIDTH-1]) ? -v : v;
   endfunction

   assign op_signed = (op == OP_MULT) || (op == OP_DIV);
   assign op_div    = (op_class(op) == CLS_DIV);
   assign last      = (count == CW'(WIDTH - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (load || finish) begin
         count <= '0;
      end else if (step) begin
         count <= count + 1'b1;
      end
   end

   always_comb begin
      add_sum = {1'b0, acc} + (low[0] ? {1'b0, divisor} : '0);
      shifted = {acc, low[WIDTH-1]};
      fits    = (shifted >= {1'b0, divisor});
      diff    = shifted[WIDTH-1:0] - divisor;
      if (is_div) begin
         acc_nxt = fits ? diff : shifted[WIDTH-1:0];
         low_nxt = {low[WIDTH-2:0], fits};
      end else begin
         acc_nxt = add_sum[WIDTH:1];
         low_nxt = {add_sum[0], low[WIDTH-1:1]};
      end
   end

   // acc/low hold the running high/low halves: partial product or remainder/quotient.
   always_ff @(posedge clk) begin
      if (load) begin
         acc     <= '0;
         low     <= magnitude(a, op_signed);
         divisor <= magnitude(b, op_signed);
         a_keep  <= a;
         is_div  <= op_div;
         neg_lo  <= op_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
         neg_hi  <= op_signed & op_div & a[WIDTH-1];
         b_zero  <= (b == '0);
      end else if (step) begin
         acc <= acc_nxt;
         low <= low_nxt;
      end
   end

   always_comb begin
      prod = neg_lo ? -{acc, low} : {acc, low};
      if (is_div) begin
         lo = neg_lo ? -low : low;
         hi = neg_hi ? -acc : acc;
         if (b_zero) begin
            lo = '1;
            hi = a_keep;
         end
      end else begin
         hi = prod[2*WIDTH-1:WIDTH];
         lo = prod[WIDTH-1:0];
      end
      div_zero = is_div & b_zero;
   end

endmodule

// File: rtl/alu_mdu.sv
// EX-stage ALU with registered single-cycle ops plus an iterative MULT/DIV unit,
// HI/LO registers and a start/busy/done handshake.
module alu_mdu
   import alu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int SHW   = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [3:0]       alu_control,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [SHW-1:0]   shamt,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             div_zero
);

   state_e                  state;
   state_e                  state_nxt;
   op_class_e               cls;
   logic                    accept_single;
   logic                    load;
   logic                    step;
   logic                    finish;
   logic                    last;
   logic [WIDTH-1:0]        alu_res;
   logic [WIDTH-1:0]        core_hi;
   logic [WIDTH-1:0]        core_lo;
   logic                    core_dz;
   logic signed [WIDTH-1:0] a_s;
   logic signed [WIDTH-1:0] b_s;

   assign cls  = op_class(alu_control);
   assign busy = (state != ST_IDLE);
   assign a_s  = a;
   assign b_s  = b;

   mdu_core #(
      .WIDTH(WIDTH)
   ) u_core (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (load),
      .step    (step),
      .finish  (finish),
      .op      (alu_control),
      .a       (a),
      .b       (b),
      .last    (last),
      .hi      (core_hi),
      .lo      (core_lo),
      .div_zero(core_dz)
   );

   always_comb begin
      alu_res = '0;
      case (alu_control)
         OP_ADD:  alu_res = a + b;
         OP_SUB:  alu_res = a - b;
         OP_SLL:  alu_res = a << shamt;
         OP_AND:  alu_res = a & b;
         OP_OR:   alu_res = a | b;
         OP_NOR:  alu_res = ~(a | b);
         OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
         OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
         OP_MFHI: alu_res = hi;
         OP_MFLO: alu_res = lo;
         default: alu_res = '0;
      endcase
   end

   always_comb begin
      state_nxt     = state;
      load          = 1'b0;
      step          = 1'b0;
      finish        = 1'b0;
      accept_single = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) begin
               if (cls == CLS_MUL || cls == CLS_DIV) begin
                  load      = 1'b1;
                  state_nxt = ST_RUN;
               end else begin
                  accept_single = 1'b1;
               end
            end
         end
         ST_RUN: begin
            step = 1'b1;
            if (last) state_nxt = ST_FIX;
         end
         ST_FIX: begin
            finish    = 1'b1;
            state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Output stage: single-cycle results on accept, MDU results on the fix-up edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         done     <= 1'b0;
         div_zero <= 1'b0;
         result   <= '0;
         zero     <= 1'b0;
         hi       <= '0;
         lo       <= '0;
      end else begin
         state    <= state_nxt;
         done     <= 1'b0;
         div_zero <= 1'b0;
         if (accept_single) begin
            result <= alu_res;
            zero   <= (alu_res == '0);
            done   <= 1'b1;
         end
         if (finish) begin
            hi       <= core_hi;
            lo       <= core_lo;
            result   <= core_lo;
            zero     <= (core_lo == '0);
            div_zero <= core_dz;
            done     <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_alu_mdu.sv
// Scoreboard bench for alu_mdu: 32-bit instance for the full op set and an
// 8-bit instance for the narrow-width corner cases.
module tb_alu_mdu;
   import alu_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, start, busy, done, zero, div_zero;
   logic [3:0]  alu_control;
   logic [31:0] a, b, result, hi, lo;
   logic [4:0]  shamt;

   logic        start8, busy8, done8, zero8, dz8;
   logic [3:0]  ctl8;
   logic [7:0]  a8, b8, result8, hi8, lo8;
   logic [2:0]  shamt8;

   alu_mdu #(.WIDTH(32), .SHW(5)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .alu_control(alu_control),
      .a(a), .b(b), .shamt(shamt), .busy(busy), .done(done), .result(result),
      .zero(zero), .hi(hi), .lo(lo), .div_zero(div_zero));

   alu_mdu #(.WIDTH(8), .SHW(3)) dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .alu_control(ctl8),
      .a(a8), .b(b8), .shamt(shamt8), .busy(busy8), .done(done8), .result(result8),
      .zero(zero8), .hi(hi8), .lo(lo8), .div_zero(dz8));

   typedef struct {
      logic [31:0] res;
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dz;
   } exp_t;

   exp_t        sb[$];
   logic [15:0] sb8[$];
   int          errors = 0;
   int          checks = 0;
   logic [31:0] m_hi = '0;
   logic [31:0] m_lo = '0;

   task automatic predict(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                          input logic [4:0] sh);
      exp_t               e;
      logic signed [63:0] sx, sy, sp;
      logic [63:0]        up;
      sx = {{32{x[31]}}, x};
      sy = {{32{y[31]}}, y};
      e.res = '0;
      e.dz  = 1'b0;
      case (op)
         OP_ADD:  e.res = x + y;
         OP_SUB:  e.res = x - y;
         OP_SLL:  e.res = x << sh;
         OP_AND:  e.res = x & y;
         OP_OR:   e.res = x | y;
         OP_NOR:  e.res = ~(x | y);
         OP_SLT:  e.res = {31'b0, (sx < sy)};
         OP_SLTU: e.res = {31'b0, (x < y)};
         OP_MULT: begin sp = sx * sy; m_hi = sp[63:32]; m_lo = sp[31:0]; end
         OP_MULTU: begin up = {32'b0, x} * {32'b0, y}; m_hi = up[63:32]; m_lo = up[31:0]; end
         OP_DIV, OP_DIVU: begin
            if (y == 32'd0) begin
               m_lo = '1; m_hi = x; e.dz = 1'b1;
            end else if (op == OP_DIV) begin
               sp = sx / sy; m_lo = sp[31:0];
               sp = sx % sy; m_hi = sp[31:0];
            end else begin
               m_lo = x / y; m_hi = x % y;
            end
         end
         OP_MFHI: e.res = m_hi;
         OP_MFLO: e.res = m_lo;
         default: e.res = '0;
      endcase
      if (op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU}) e.res = m_lo;
      e.hi = m_hi;
      e.lo = m_lo;
      sb.push_back(e);
   endtask

   task automatic issue(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                        input logic [4:0] sh, input bit pred);
      @(negedge clk);
      alu_control = op; a = x; b = y; shamt = sh; start = 1'b1;
      if (pred) predict(op, x, y, sh);
      @(negedge clk);
      start = 1'b0;
      a = $urandom; b = $urandom; alu_control = 4'($urandom);
   endtask

   task automatic wait_done(output int waited, output int busy_cycles, output bit ok);
      waited = 0; busy_cycles = 0; ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (done) begin ok = 1'b1; break; end
         if (busy) busy_cycles++;
         waited++;
         @(negedge clk);
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if ({busy, done, div_zero, zero} !== 4'b0)
         begin errors++; $display("FAIL reset_flags: got %b expected 0000", {busy, done, div_zero, zero}); end
      checks++; if (result !== 32'd0) begin errors++; $display("FAIL reset_result: got %h expected 0", result); end
      checks++; if ({hi, lo} !== 64'd0) begin errors++; $display("FAIL reset_hilo: got %h expected 0", {hi, lo}); end
      rst_n = 1'b1;
      m_hi = '0; m_lo = '0;
   endtask

   task automatic test_single;
      logic [3:0]  ops[11];
      logic [31:0] xs[11], ys[11];
      logic [4:0]  shs[11];
      exp_t        e;
      int          w, bc;
      bit          ok;
      ops = '{OP_ADD, OP_SUB, OP_SLT, OP_SLTU, OP_SLL, OP_AND, OP_OR, OP_NOR, 4'b0101, 4'b1101, OP_SLT};
      xs  = '{32'd4, 32'd4, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000003, 32'hF0F01234,
              32'h0F000001, 32'h12345678, 32'h5, 32'h7, 32'd5};
      ys  = '{32'd1, 32'd4, 32'd1, 32'd1, 32'h0, 32'hFF00FF00, 32'h00F00010,
              32'h00FF00FF, 32'h5, 32'h9, 32'hFFFFFFFB};
      shs = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd31, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0};
      for (int i = 0; i < 11; i++) begin
         issue(ops[i], xs[i], ys[i], shs[i], 1'b1);
         wait_done(w, bc, ok);
         e = sb.pop_front();
         checks++; if (!ok || w != 0 || bc != 0)
            begin errors++; $display("FAIL single_latency[%0d]: got wait=%0d busy=%0d expected 0/0", i, w, bc); end
         checks++; if (result !== e.res)
            begin errors++; $display("FAIL single_result[%0d]: got %h expected %h", i, result, e.res); end
         checks++; if (zero !== (e.res == 32'd0))
            begin errors++; $display("FAIL single_zero[%0d]: got %b expected %b", i, zero, (e.res == 32'd0)); end
         checks++; if (hi !== e.hi || lo !== e.lo)
            begin errors++; $display("FAIL single_hilo[%0d]: got %h/%h expected %h/%h", i, hi, lo, e.hi, e.lo); end
      end
   endtask

   task automatic test_back_to_back;
      logic [3:0]  ops[4];
      logic [31:0] xs[4], ys[4];
      exp_t        e;
      ops = '{OP_ADD, OP_SUB, OP_OR, OP_SLL};
      xs  = '{32'd10, 32'd5, 32'hA0A0A0A0, 32'h00000001};
      ys  = '{32'd20, 32'd9, 32'h05050505, 32'h0};
      for (int k = 0; k <= 4; k++) begin
         @(negedge clk);
         if (k > 0) begin
            e = sb.pop_front();
            checks++; if (done !== 1'b1 || result !== e.res)
               begin errors++; $display("FAIL b2b[%0d]: got done=%b %h expected 1 %h", k, done, result, e.res); end
         end
         if (k < 4) begin
            alu_control = ops[k]; a = xs[k]; b = ys[k]; shamt = 5'(k + 3); start = 1'b1;
            predict(ops[k], xs[k], ys[k], 5'(k + 3));
         end else begin
            start = 1'b0;
         end
      end
      @(negedge clk);
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_pulse: got %b expected 0", done); end
   endtask

   task automatic test_mult;
      logic [3:0]  ops[8];
      logic [31:0] xs[8], ys[8];
      exp_t        e;
      int          w, bc;
      bit          ok;
      ops = '{OP_MULTU, OP_MULT, OP_MULT, OP_MULT, OP_MULTU, OP_MULT, OP_MULTU, OP_MULT};
      xs  = '{32'hFFFFFFFF, 32'hFFFFFFFD, 32'h80000000, 32'd7, $urandom, $urandom, $urandom, 32'd0};
      ys  = '{32'd2, 32'd5, 32'h80000000, 32'hFFFFFFF7, $urandom, $urandom, $urandom, 32'hFFFFFFFF};
      for (int i = 0; i < 8; i++) begin
         issue(ops[i], xs[i], ys[i], 5'd0, 1'b1);
         wait_done(w, bc, ok);
         e = sb.pop_front();
         checks++; if (!ok || bc != 33)
            begin errors++; $display("FAIL mult_busy[%0d]: got %0d expected 33", i, bc); end
         checks++; if (hi !== e.hi || lo !== e.lo)
            begin errors++; $display("FAIL mult_hilo[%0d]: got %h/%h expected %h/%h", i, hi, lo, e.hi, e.lo); end
         checks++; if (result !== e.res || zero !== (e.res == 32'd0) || div_zero !== 1'b0)
            begin errors++; $display("FAIL mult_result[%0d]: got %h z=%b dz=%b expected %h", i, result, zero, div_zero, e.res); end
      end
   endtask

   task automatic test_div;
      logic [3:0]  ops[9];
      logic [31:0] xs[9], ys[9];
      exp_t        e;
      int          w, bc;
      bit          ok;
      ops = '{OP_DIV, OP_DIVU, OP_DIV, OP_DIVU, OP_DIV, OP_DIV, OP_DIVU, OP_DIV, OP_DIVU};
      xs  = '{32'hFFFFFFF9, 32'd7, 32'h80000000, 32'd9, 32'hFFFFFFFB, 32'd100, $urandom, $urandom, 32'd3};
      ys  = '{32'd2, 32'd2, 32'hFFFFFFFF, 32'd0, 32'd0, 32'hFFFFFFF9,
              ($urandom | 32'h1), ($urandom_range(1000, 1) | 32'h80000000), 32'd10};
      for (int i = 0; i < 9; i++) begin
         issue(ops[i], xs[i], ys[i], 5'd0, 1'b1);
         wait_done(w, bc, ok);
         e = sb.pop_front();
         checks++; if (!ok || bc != 33)
            begin errors++; $display("FAIL div_busy[%0d]: got %0d expected 33", i, bc); end
         checks++; if (hi !== e.hi || lo !== e.lo)
            begin errors++; $display("FAIL div_hilo[%0d]: got %h/%h expected %h/%h", i, hi, lo, e.hi, e.lo); end
         checks++; if (div_zero !== e.dz)
            begin errors++; $display("FAIL div_zero_flag[%0d]: got %b expected %b", i, div_zero, e.dz); end
         checks++; if (result !== e.res || zero !== (e.res == 32'd0))
            begin errors++; $display("FAIL div_result[%0d]: got %h z=%b expected %h", i, result, zero, e.res); end
      end
   endtask

   task automatic test_busy_ignore;
      exp_t e;
      int   w, bc;
      bit   ok;
      issue(OP_MULTU, 32'h12345678, 32'h9ABCDEF0, 5'd0, 1'b1);
      repeat (4) @(negedge clk);
      alu_control = OP_ADD; a = 32'd1; b = 32'd1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      wait_done(w, bc, ok);
      checks++; if (!ok || bc + 6 != 33)
         begin errors++; $display("FAIL busy_ignore_len: got %0d expected 33", bc + 6); end
      alu_control = OP_MFLO; start = 1'b1;
      predict(OP_MFLO, 32'd0, 32'd0, 5'd0);
      e = sb.pop_front();
      checks++; if (lo !== e.lo || hi !== e.hi)
         begin errors++; $display("FAIL busy_ignore_hilo: got %h/%h expected %h/%h", hi, lo, e.hi, e.lo); end
      @(negedge clk);
      start = 1'b0;
      e = sb.pop_front();
      checks++; if (done !== 1'b1 || result !== e.res)
         begin errors++; $display("FAIL mflo_on_done: got done=%b %h expected 1 %h", done, result, e.res); end
      @(negedge clk);
      checks++; if (done !== 1'b0 || busy !== 1'b0)
         begin errors++; $display("FAIL ignored_start: got done=%b busy=%b expected 0/0", done, busy); end
   endtask

   task automatic test_abort;
      exp_t e;
      int   w, bc, seen;
      bit   ok;
      issue(OP_DIVU, 32'hDEADBEEF, 32'h00000013, 5'd0, 1'b0);
      repeat (10) @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy); end
      checks++; if ({hi, lo} !== 64'd0) begin errors++; $display("FAIL abort_hilo: got %h expected 0", {hi, lo}); end
      checks++; if (result !== 32'd0 || zero !== 1'b0 || div_zero !== 1'b0)
         begin errors++; $display("FAIL abort_outputs: got %h z=%b dz=%b expected 0", result, zero, div_zero); end
      seen = 0;
      repeat (3) begin @(negedge clk); if (done) seen++; end
      rst_n = 1'b1;
      m_hi = '0; m_lo = '0;
      repeat (3) begin @(negedge clk); if (done) seen++; end
      checks++; if (seen != 0) begin errors++; $display("FAIL abort_no_done: got %0d pulses expected 0", seen); end
      issue(OP_MULTU, 32'd3, 32'd4, 5'd0, 1'b1);
      wait_done(w, bc, ok);
      e = sb.pop_front();
      checks++; if (!ok || bc != 33 || lo !== e.lo || hi !== e.hi)
         begin errors++; $display("FAIL abort_recover: got busy=%0d %h/%h expected 33 %h/%h", bc, hi, lo, e.hi, e.lo); end
   endtask

   task automatic test_width8;
      logic [3:0]  ops[4];
      logic [7:0]  xs[4], ys[4];
      logic [15:0] exps[4];
      logic [15:0] e;
      int          bc;
      bit          ok;
      ops  = '{OP_MULT, OP_MULTU, OP_DIV, OP_DIVU};
      xs   = '{8'h80, 8'hFF, 8'h80, 8'h25};
      ys   = '{8'h80, 8'hFF, 8'hFF, 8'h00};
      exps = '{16'h4000, 16'hFE01, 16'h0080, 16'h25FF};
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         ctl8 = ops[i]; a8 = xs[i]; b8 = ys[i]; shamt8 = 3'd0; start8 = 1'b1;
         sb8.push_back(exps[i]);
         @(negedge clk);
         start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
         bc = 0; ok = 1'b0;
         for (int k = 0; k < 40; k++) begin
            if (done8) begin ok = 1'b1; break; end
            if (busy8) bc++;
            @(negedge clk);
         end
         e = sb8.pop_front();
         checks++; if (!ok || bc != 9)
            begin errors++; $display("FAIL w8_busy[%0d]: got %0d expected 9", i, bc); end
         checks++; if ({hi8, lo8} !== e || result8 !== e[7:0])
            begin errors++; $display("FAIL w8_hilo[%0d]: got %h res=%h expected %h", i, {hi8, lo8}, result8, e); end
      end
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; alu_control = '0; a = '0; b = '0; shamt = '0;
      start8 = 1'b0; ctl8 = '0; a8 = '0; b8 = '0; shamt8 = '0;
      test_reset;
      test_single;
      test_back_to_back;
      test_mult;
      test_div;
      test_busy_ignore;
      test_abort;
      test_width8;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/alu_mdu.md
# alu_mdu

Parametrised, clocked successor to the single-cycle MIPS ALU. It executes the existing ALU ops in one registered cycle and adds iterative MULT/MULTU/DIV/DIVU with architectural HI/LO registers and MFHI/MFLO reads, behind a start/busy/done handshake. It sits in the EX stage; the pipeline stalls on `busy`.

## Interface
- `WIDTH`, 32: operand/result width, even, ≥8
- `SHW`, 5: shift-amount width, must equal clog2(WIDTH)
- `clk` in 1: clock, all state on rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `start` in 1: request; accepted only when `busy`=0
- `alu_control` in 4: op code, sampled on accept
- `a`, `b` in WIDTH: operands, sampled on accept
- `shamt` in SHW: shift amount, sampled on accept
- `busy` out 1: iterative op in flight
- `done` out 1: one-cycle pulse, `result`/`zero`/`hi`/`lo` valid
- `result` out WIDTH: registered result, held until next done
- `zero` out 1: `result`==0, registered with `result`
- `hi`, `lo` out WIDTH: architectural HI/LO
- `div_zero` out 1: pulses with `done` for DIV/DIVU when `b`==0

## Operation
- Op codes: ADD 0010, SUB 0110, SLL 0011, AND 0000, OR 0001, NOR 1100, SLT 0111 (signed), SLTU 0100, MULT 1000, MULTU 1001, DIV 1010, DIVU 1011, MFHI 1110, MFLO 1111. Unlisted codes: `result`=0, `zero`=1, `done` still pulses, HI/LO unchanged.
- ADD/SUB wrap modulo 2^WIDTH, no overflow flag. SLL shifts `a` left by `shamt`, zero-fill.
- Mult ops: {HI,LO} = full 2·WIDTH-bit product. MULT is signed, MULTU unsigned. Radix-2 shift-add on magnitudes, with a sign fix-up cycle.
- Div ops: LO = quotient, HI = remainder. Restoring division on magnitudes. Signed quotient sign = sign(a) xor sign(b); remainder sign = sign(a), truncating toward zero. Signed min / −1 yields LO = min, HI = 0.
- Divide by zero, signed or unsigned: LO = all ones, HI = `a`, `div_zero`=1.
- Mult/div ops drive `result` = new LO.
- MFHI/MFLO return current HI/LO in `result`.
- FSM states are IDLE, RUN, FIX.
  - IDLE: start and single-cycle op → stay IDLE. Start and mult/div → RUN, count = 0.
  - RUN: count increments each cycle. count = WIDTH−1 → FIX.
  - FIX: apply signs, write HI/LO → IDLE.

## Timing
- Reset: `busy`, `done`, `div_zero`, `zero` = 0; `result`, `hi`, `lo` = 0; FSM = IDLE; counter = 0.
- Single-cycle op accepted at edge E0 → `result`/`zero` updated at E0, `done`=1 for the cycle after E0, `busy` stays 0. Back-to-back starts give one result per cycle.
- Iterative op accepted at E0:
  - `busy`=1 after E0 through E(WIDTH+1).
  - HI/LO/`result` written at E(WIDTH+1); `done`=1 for the following cycle.
  - Latency WIDTH+1 cycles; the next start can be accepted on the `done` cycle.
- `start` while `busy`=1 is ignored and not queued. Operand changes during RUN have no effect.
- MFHI/MFLO issued on the `done` cycle of a mult/div see the new HI/LO.
- Reset asserted mid-operation aborts immediately: all outputs return to reset values, no `done`.

## Structure
- Shared package `alu_pkg`: 4-bit op-code localparams, an op-class function (single / mul / div / move), and the FSM state enum.
- Sub-module `mdu_core`: holds the iterative mult/div datapath, counter and sign fix-up. It exposes load/step/finish and returns {hi, lo}.
- Top level `alu_mdu` holds the single-cycle ops, the FSM, HI/LO and output registers.

## Test plan
- Reset with `rst_n`=0: all outputs 0. Then ADD a=4, b=1 → `result`=5, `done` the cycle after accept. SUB 4−4 → `result`=0, `zero`=1. SLT a=−1, b=1 → 1; SLTU with the same operands → 0.
- MULTU a=0xFFFFFFFF, b=2 → HI=1, LO=0xFFFFFFFE after exactly 33 busy cycles. MULT a=−3, b=5 → HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- DIV a=−7, b=2 → LO=−3, HI=−1. DIVU a=7, b=2 → LO=3, HI=1. DIV a=0x80000000, b=−1 → LO=0x80000000, HI=0.
- DIVU a=9, b=0 → LO=0xFFFFFFFF, HI=9, `div_zero` pulses with `done`.
- `start` pulsed while `busy` → no effect. MFLO issued on the `done` cycle → returns the new LO.
- `rst_n` dropped at RUN count 10 → `busy`=0, HI=LO=0, no `done` pulse.
- Repeat with WIDTH=8, SHW=3: MULT −128×−128 → {HI,LO}=0x4000.
